jelly_rtos_semop_arbiter: RTL and testbench
===========================================

# jelly_rtos_semop_arbiter

Shares one RTOS semaphore operation bus between NUM_REQ requesters (CPU cores, bus bridges, timer service). Round-robin arbitration with valid/ready handshake; one operation per cycle drives the common op bus of all jelly_rtos_semaphore instances. Per-operation result (acknowledge/acquired) returns to the issuing requester, and semaphore wakeup pulses are forwarded to the task scheduler.

## Interface
Parameters:
- NUM_REQ, 4, requester count (2..16)
- SEMID_WIDTH, 4, semaphore ID width
- TSKID_WIDTH, 4, task ID width
- TSKPRI_WIDTH, 4, task priority width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cke  in  1  clock enable; low freezes all state
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  one-hot grant, combinational
- req_op  in  NUM_REQ×2  opcode (SIG=0, POL=1, WAI=2, REL=3)
- req_semid  in  NUM_REQ×SEMID_WIDTH  target semaphore
- req_tskid  in  NUM_REQ×TSKID_WIDTH  calling/target task
- req_tskpri  in  NUM_REQ×TSKPRI_WIDTH  task priority (WAI only)
- op_semid / op_tskid / op_tskpri  out  widths as above  registered op bus
- sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid  out  1 each  registered, at most one high
- pol_sem_ack  in  1  OR of all semaphore pol_sem_ack
- sem_wakeup_tskid  in  TSKID_WIDTH  merged semaphore wakeup ID
- sem_wakeup_valid  in  1  merged semaphore wakeup valid
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_ack  out  1  result for the responding requester
- wakeup_tskid  out  TSKID_WIDTH  registered wakeup to scheduler
- wakeup_valid  out  1  registered wakeup pulse

## Operation
- Eligible requester i: req_valid[i] && !busy[i]. Arbiter picks first eligible searching upward from rr_ptr, wrapping modulo NUM_REQ.
- req_ready[i] high only for the winner and only when cke=1; transfer = req_valid[i] && req_ready[i].
- On transfer: op bus registers load winner's fields, matching opcode valid set, busy[i] set, rr_ptr ← (i+1) mod NUM_REQ, issue_id ← i.
- No transfer: all four op valids cleared next cycle; op_* data hold last value.
- busy[i] clears when rsp_valid[i] fires; requester i is ineligible while busy (one outstanding op per requester).
- Response, sampled in the cycle the op bus is valid:
  - SIG: rsp_ack=1.
  - POL: rsp_ack=pol_sem_ack.
  - WAI: rsp_ack=sem_wakeup_valid && sem_wakeup_tskid==op_tskid (immediate acquire); 0 = task queued.
  - REL: rsp_ack=1.
- sem_wakeup_valid/tskid registered unchanged to wakeup_valid/tskid every enabled cycle, including WAI immediate acquisition.
- Semaphore ID not present: semaphores give no ack → POL/WAI return rsp_ack=0; no error flag.
- Reset values: req_ready=0, all op valids=0, op_semid/op_tskid/op_tskpri=0, rsp_valid=0, rsp_ack=0, wakeup_valid=0, wakeup_tskid=0, busy=0, rr_ptr=0.
- Reset mid-operation: in-flight op and pending response discarded; requesters must reissue.

## Timing
- Cycle T: grant/transfer. T+1: op bus valid, semaphores update. T+2: rsp_valid/rsp_ack and wakeup registered out.
- Throughput: one op per cycle across requesters; per requester one op every 3 cycles (busy from T+1 through T+2, eligible again at T+3).
- cke=0: req_ready=0, all registers hold including op valids (semaphores also hold under shared cke); no pulse duplicated or lost.
- Simultaneous requests: round-robin; starvation bound NUM_REQ−1 grants.
- rsp_valid and a new transfer from other requesters may coincide; independent.

## Structure
- jelly_rtos_pkg: typedef enum logic [1:0] semop_t {SEMOP_SIG, SEMOP_POL, SEMOP_WAI, SEMOP_REL}.
- Sub-module jelly_rtos_rr_arbiter (NUM_REQ; request vector, rr_ptr in → one-hot grant, grant index out), reusable for other RTOS object buses (event flags, mailboxes).
- Top: busy vector, op bus registers, issue_id/opcode pipeline stage, response and wakeup registers.

## Test plan
- Reset INIT_SEMCNT=1: requester 0 POL sem 0 → op bus at T+1, rsp_valid=0001, rsp_ack=1 at T+2; second POL → rsp_ack=0.
- All four requesters valid continuously, each SIG sem 0 → grants 0,1,2,3,0…, one op per cycle, each requester regranted no earlier than 3 cycles after previous grant.
- semcnt=0: req 1 WAI tsk 5 → rsp_ack=0; req 2 SIG sem 0 → wakeup_valid=1, wakeup_tskid=5, rsp_ack=1 for req 2.
- semcnt=2: WAI tsk 3 → rsp_ack=1, wakeup_tskid=3 forwarded; semcnt reads 1.
- cke low 3 cycles with op bus valid → valid held, semcnt decrements exactly once; response arrives after cke returns.
- Reset asserted at T+1 of an in-flight POL → no rsp_valid, busy=0, rr_ptr=0, all outputs zero.

Source files
------------

// File: rtl/jelly_rtos_pkg.sv
// Shared types for the RTOS object-operation buses.
// The semaphore opcode encoding is fixed by the requester-side software.

package jelly_rtos_pkg;

    // Width of the opcode field carried on every requester port
    localparam int SEMOP_WIDTH = 2;

    typedef enum logic [SEMOP_WIDTH-1:0] {
        SEMOP_SIG = 2'd0,   // signal: release one count or wake one waiter
        SEMOP_POL = 2'd1,   // poll: non-blocking acquire
        SEMOP_WAI = 2'd2,   // wait: acquire or queue the calling task
        SEMOP_REL = 2'd3    // release-wait: pull a task out of the wait queue
    } semop_t;

endpackage

// File: rtl/jelly_rtos_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector upward from rr_ptr, wrapping modulo NUM_REQ,
// and returns the first set request as a one-hot grant plus its index.
// Kept free of state so the owner decides when the pointer advances; this
// lets the same block serve the event-flag and mailbox buses as well.

module jelly_rtos_rr_arbiter
#(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0]   request,
    input  logic [PTR_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [PTR_WIDTH-1:0] grant_index,
    output logic                 grant_valid
);

    // Candidate k is the requester k places above the pointer (wrapped)
    logic [PTR_WIDTH-1:0] cand_index   [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_request;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [PTR_WIDTH:0] cand_sum;
        logic [PTR_WIDTH:0] cand_wrapped;

        // rr_ptr < NUM_REQ and gi < NUM_REQ, so one subtraction is enough
        assign cand_sum      = {1'b0, rr_ptr} + (PTR_WIDTH+1)'(gi);
        assign cand_wrapped  = (cand_sum >= (PTR_WIDTH+1)'(NUM_REQ))
                             ? cand_sum - (PTR_WIDTH+1)'(NUM_REQ)
                             : cand_sum;
        assign cand_index[gi]   = cand_wrapped[PTR_WIDTH-1:0];
        assign cand_request[gi] = request[cand_index[gi]];
    end

    // Pick the lowest-offset candidate; walking downward lets the nearest win
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_request[k]) begin
                grant_valid = 1'b1;
                grant_index = cand_index[k];
            end
        end
        if (grant_valid) begin
            grant[grant_index] = 1'b1;
        end
    end

endmodule

// File: rtl/jelly_rtos_semop_arbiter.sv
// Semaphore operation bus arbiter.
// Several requesters share the single op bus that feeds every semaphore
// instance. One op is issued per cycle in round-robin order; each requester
// may have one op outstanding. The result (ack/acquired) is returned to the
// issuer two cycles after the grant, and semaphore wakeups are forwarded to
// the scheduler through one register stage.

module jelly_rtos_semop_arbiter
    import jelly_rtos_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SEMID_WIDTH  = 4,
    parameter int TSKID_WIDTH  = 4,
    parameter int TSKPRI_WIDTH = 4
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cke,

    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*SEMOP_WIDTH-1:0]    req_op,
    input  logic [NUM_REQ*SEMID_WIDTH-1:0]    req_semid,
    input  logic [NUM_REQ*TSKID_WIDTH-1:0]    req_tskid,
    input  logic [NUM_REQ*TSKPRI_WIDTH-1:0]   req_tskpri,

    output logic [SEMID_WIDTH-1:0]            op_semid,
    output logic [TSKID_WIDTH-1:0]            op_tskid,
    output logic [TSKPRI_WIDTH-1:0]           op_tskpri,
    output logic                              sig_sem_valid,
    output logic                              pol_sem_valid,
    output logic                              wai_sem_valid,
    output logic                              rel_wai_valid,

    input  logic                              pol_sem_ack,
    input  logic [TSKID_WIDTH-1:0]            sem_wakeup_tskid,
    input  logic                              sem_wakeup_valid,

    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic                              rsp_ack,

    output logic [TSKID_WIDTH-1:0]            wakeup_tskid,
    output logic                              wakeup_valid
);

    localparam int PTR_WIDTH = $clog2(NUM_REQ);

    // ------------------------------------------------------------------
    // Per-requester views of the flattened request fields
    // ------------------------------------------------------------------
    logic [SEMOP_WIDTH-1:0]  req_op_array     [NUM_REQ];
    logic [SEMID_WIDTH-1:0]  req_semid_array  [NUM_REQ];
    logic [TSKID_WIDTH-1:0]  req_tskid_array  [NUM_REQ];
    logic [TSKPRI_WIDTH-1:0] req_tskpri_array [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_op_array[gi]     = req_op[gi*SEMOP_WIDTH +: SEMOP_WIDTH];
        assign req_semid_array[gi]  = req_semid[gi*SEMID_WIDTH +: SEMID_WIDTH];
        assign req_tskid_array[gi]  = req_tskid[gi*TSKID_WIDTH +: TSKID_WIDTH];
        assign req_tskpri_array[gi] = req_tskpri[gi*TSKPRI_WIDTH +: TSKPRI_WIDTH];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]      busy_reg,       busy_next;
    logic [PTR_WIDTH-1:0]    rr_ptr_reg,     rr_ptr_next;
    logic [PTR_WIDTH-1:0]    issue_id_reg,   issue_id_next;

    logic [SEMID_WIDTH-1:0]  op_semid_reg,   op_semid_next;
    logic [TSKID_WIDTH-1:0]  op_tskid_reg,   op_tskid_next;
    logic [TSKPRI_WIDTH-1:0] op_tskpri_reg,  op_tskpri_next;
    logic                    sig_valid_reg,  sig_valid_next;
    logic                    pol_valid_reg,  pol_valid_next;
    logic                    wai_valid_reg,  wai_valid_next;
    logic                    rel_valid_reg,  rel_valid_next;

    logic [NUM_REQ-1:0]      rsp_valid_reg,  rsp_valid_next;
    logic                    rsp_ack_reg,    rsp_ack_next;
    logic [TSKID_WIDTH-1:0]  wakeup_tskid_reg, wakeup_tskid_next;
    logic                    wakeup_valid_reg, wakeup_valid_next;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_WIDTH-1:0] arb_index;
    logic                 arb_valid;
    logic                 transfer;
    semop_t               win_op;

    // A requester with an op still in flight is masked out of arbitration
    assign eligible = req_valid & ~busy_reg;

    jelly_rtos_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_rr_arbiter (
        .request     (eligible),
        .rr_ptr      (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_index (arb_index),
        .grant_valid (arb_valid)
    );

    // No grant while frozen or in reset, so nothing can be lost in a stall
    assign transfer  = cke && !reset && arb_valid;
    assign req_ready = transfer ? arb_grant : '0;
    assign win_op    = semop_t'(req_op_array[arb_index]);

    logic op_active;
    assign op_active = sig_valid_reg | pol_valid_reg | wai_valid_reg | rel_valid_reg;

    // Next-state: issue stage, response stage and wakeup forwarding
    always_comb begin
        busy_next      = busy_reg & ~rsp_valid_reg;
        rr_ptr_next    = rr_ptr_reg;
        issue_id_next  = issue_id_reg;
        op_semid_next  = op_semid_reg;
        op_tskid_next  = op_tskid_reg;
        op_tskpri_next = op_tskpri_reg;
        sig_valid_next = 1'b0;
        pol_valid_next = 1'b0;
        wai_valid_next = 1'b0;
        rel_valid_next = 1'b0;

        if (transfer) begin
            busy_next      = busy_next | arb_grant;
            rr_ptr_next    = (arb_index == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : arb_index + 1'b1;
            issue_id_next  = arb_index;
            op_semid_next  = req_semid_array[arb_index];
            op_tskid_next  = req_tskid_array[arb_index];
            op_tskpri_next = req_tskpri_array[arb_index];
            case (win_op)
                SEMOP_SIG: sig_valid_next = 1'b1;
                SEMOP_POL: pol_valid_next = 1'b1;
                SEMOP_WAI: wai_valid_next = 1'b1;
                SEMOP_REL: rel_valid_next = 1'b1;
                default:   sig_valid_next = 1'b0;
            endcase
        end

        // Result is sampled while the op is on the bus, i.e. one cycle after issue
        rsp_valid_next = '0;
        rsp_ack_next   = 1'b0;
        if (op_active) begin
            rsp_valid_next[issue_id_reg] = 1'b1;
            if (sig_valid_reg || rel_valid_reg) begin
                rsp_ack_next = 1'b1;
            end else if (pol_valid_reg) begin
                rsp_ack_next = pol_sem_ack;
            end else begin
                // WAI acquired immediately iff the semaphore woke the caller itself
                rsp_ack_next = sem_wakeup_valid && (sem_wakeup_tskid == op_tskid_reg);
            end
        end

        wakeup_valid_next = sem_wakeup_valid;
        wakeup_tskid_next = sem_wakeup_tskid;
    end

    // Register update; cke low freezes everything including the pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg         <= '0;
            rr_ptr_reg       <= '0;
            issue_id_reg     <= '0;
            op_semid_reg     <= '0;
            op_tskid_reg     <= '0;
            op_tskpri_reg    <= '0;
            sig_valid_reg    <= 1'b0;
            pol_valid_reg    <= 1'b0;
            wai_valid_reg    <= 1'b0;
            rel_valid_reg    <= 1'b0;
            rsp_valid_reg    <= '0;
            rsp_ack_reg      <= 1'b0;
            wakeup_tskid_reg <= '0;
            wakeup_valid_reg <= 1'b0;
        end else if (cke) begin
            busy_reg         <= busy_next;
            rr_ptr_reg       <= rr_ptr_next;
            issue_id_reg     <= issue_id_next;
            op_semid_reg     <= op_semid_next;
            op_tskid_reg     <= op_tskid_next;
            op_tskpri_reg    <= op_tskpri_next;
            sig_valid_reg    <= sig_valid_next;
            pol_valid_reg    <= pol_valid_next;
            wai_valid_reg    <= wai_valid_next;
            rel_valid_reg    <= rel_valid_next;
            rsp_valid_reg    <= rsp_valid_next;
            rsp_ack_reg      <= rsp_ack_next;
            wakeup_tskid_reg <= wakeup_tskid_next;
            wakeup_valid_reg <= wakeup_valid_next;
        end
    end

    assign op_semid      = op_semid_reg;
    assign op_tskid      = op_tskid_reg;
    assign op_tskpri     = op_tskpri_reg;
    assign sig_sem_valid = sig_valid_reg;
    assign pol_sem_valid = pol_valid_reg;
    assign wai_sem_valid = wai_valid_reg;
    assign rel_wai_valid = rel_valid_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_ack       = rsp_ack_reg;
    assign wakeup_tskid  = wakeup_tskid_reg;
    assign wakeup_valid  = wakeup_valid_reg;

endmodule

// File: tb/tb_jelly_rtos_semop_arbiter.sv
// Bench for jelly_rtos_semop_arbiter: a behavioural semaphore environment
// answers the DUT op bus, while a reference model predicts grants, op bus
// contents, responses and wakeups from the request stream alone.

module tb_jelly_rtos_semop_arbiter;
    import jelly_rtos_pkg::*;

    localparam int N    = 4;
    localparam int SW   = 4;
    localparam int TW   = 4;
    localparam int PW   = 4;
    localparam int NSEM = 4;     // semaphore IDs 0..3 exist, others are absent
    localparam int QD   = 512;
    localparam int SZ   = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, cke;
    logic [N-1:0]       req_valid, req_ready;
    logic [N*2-1:0]     req_op;
    logic [N*SW-1:0]    req_semid;
    logic [N*TW-1:0]    req_tskid;
    logic [N*PW-1:0]    req_tskpri;
    logic [SW-1:0]      op_semid;
    logic [TW-1:0]      op_tskid;
    logic [PW-1:0]      op_tskpri;
    logic               sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid;
    logic               pol_sem_ack;
    logic [TW-1:0]      sem_wakeup_tskid;
    logic               sem_wakeup_valid;
    logic [N-1:0]       rsp_valid;
    logic               rsp_ack;
    logic [TW-1:0]      wakeup_tskid;
    logic               wakeup_valid;

    jelly_rtos_semop_arbiter #(
        .NUM_REQ(N), .SEMID_WIDTH(SW), .TSKID_WIDTH(TW), .TSKPRI_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_semid(req_semid), .req_tskid(req_tskid), .req_tskpri(req_tskpri),
        .op_semid(op_semid), .op_tskid(op_tskid), .op_tskpri(op_tskpri),
        .sig_sem_valid(sig_sem_valid), .pol_sem_valid(pol_sem_valid),
        .wai_sem_valid(wai_sem_valid), .rel_wai_valid(rel_wai_valid),
        .pol_sem_ack(pol_sem_ack), .sem_wakeup_tskid(sem_wakeup_tskid),
        .sem_wakeup_valid(sem_wakeup_valid),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .wakeup_tskid(wakeup_tskid), .wakeup_valid(wakeup_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Semaphore state: instance 0 is the environment driven by the DUT op bus,
    // instance 1 is the reference model driven by the granted requests.
    int sc [2][NSEM];
    int wq [2][NSEM][QD];
    int wl [2][NSEM];

    // Semaphore semantics: SIG wakes the oldest waiter or counts up, POL takes
    // a count if any, WAI takes a count (waking the caller) or queues, REL
    // removes the task from the wait queue. Absent IDs never acknowledge.
    task automatic sem_apply(input int inst, input int op, input int s, input int t,
                             input bit commit, output bit ack, output bit wv, output int wt);
        ack = 1'b0; wv = 1'b0; wt = 0;
        if (s >= NSEM) begin
            ack = (op == 0 || op == 3);
            return;
        end
        case (op)
            0: begin
                ack = 1'b1;
                if (wl[inst][s] > 0) begin
                    wv = 1'b1; wt = wq[inst][s][0];
                    if (commit) begin
                        for (int k = 0; k < wl[inst][s] - 1; k++) wq[inst][s][k] = wq[inst][s][k+1];
                        wl[inst][s]--;
                    end
                end else if (commit) sc[inst][s]++;
            end
            1: begin
                ack = (sc[inst][s] > 0);
                if (commit && ack) sc[inst][s]--;
            end
            2: begin
                if (sc[inst][s] > 0) begin
                    ack = 1'b1; wv = 1'b1; wt = t;
                    if (commit) sc[inst][s]--;
                end else if (commit && wl[inst][s] < QD) begin
                    wq[inst][s][wl[inst][s]] = t;
                    wl[inst][s]++;
                end
            end
            default: begin
                ack = 1'b1;
                if (commit) begin
                    for (int k = 0; k < wl[inst][s]; k++) begin
                        if (wq[inst][s][k] == t) begin
                            for (int m = k; m < wl[inst][s] - 1; m++) wq[inst][s][m] = wq[inst][s][m+1];
                            wl[inst][s]--;
                            break;
                        end
                    end
                end
            end
        endcase
    endtask

    // Reference model: expected outputs indexed by the number of enabled edges since reset
    int         c, ptr_m;
    int         last_g [N];
    logic [3:0] e_opv [SZ];
    int         e_sem [SZ], e_tsk [SZ], e_pri [SZ];
    logic [N-1:0] e_rspv [SZ];
    bit         e_rspack [SZ], e_wkv [SZ];
    int         e_wkt [SZ];
    int         l_sem, l_tsk, l_pri;

    task automatic reset_model();
        c = 0; ptr_m = 0; l_sem = 0; l_tsk = 0; l_pri = 0;
        for (int i = 0; i < N; i++) last_g[i] = -100;
        for (int k = 0; k < SZ; k++) begin
            e_opv[k] = '0; e_sem[k] = 0; e_tsk[k] = 0; e_pri[k] = 0;
            e_rspv[k] = '0; e_rspack[k] = 1'b0; e_wkv[k] = 1'b0; e_wkt[k] = 0;
        end
    endtask

    task automatic set_sem(input int s, input int n);
        for (int inst = 0; inst < 2; inst++) begin
            sc[inst][s] = n; wl[inst][s] = 0;
        end
    endtask

    task automatic set_req(input int i, input bit v, input int op, input int s, input int t, input int p);
        req_valid[i]           = v;
        req_op[i*2 +: 2]       = 2'(op);
        req_semid[i*SW +: SW]  = SW'(s);
        req_tskid[i*TW +: TW]  = TW'(t);
        req_tskpri[i*PW +: PW] = PW'(p);
    endtask

    task automatic idle_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0, 0, 0);
    endtask

    // One clock: environment reacts, outputs are checked mid-cycle, model advances
    task automatic cycle();
        int op_now, g, idx, gop, gs, gt, gp, t;
        bit a, v;
        logic [N-1:0] exp_ready;

        op_now = sig_sem_valid ? 0 : pol_sem_valid ? 1 : wai_sem_valid ? 2 : rel_wai_valid ? 3 : -1;
        pol_sem_ack = 1'b0; sem_wakeup_valid = 1'b0; sem_wakeup_tskid = '0;
        if (op_now >= 0) begin
            sem_apply(0, op_now, int'(op_semid), int'(op_tskid), 1'b0, a, v, t);
            pol_sem_ack      = (op_now == 1) && a;
            sem_wakeup_valid = v;
            sem_wakeup_tskid = TW'(t);
        end

        @(negedge clk);
        g = -1; exp_ready = '0;
        if (cke && !reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g < 0 && req_valid[idx] && c >= last_g[idx] + 3) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;

        check("req_ready",    req_ready, exp_ready);
        check("op_valids",    {rel_wai_valid, wai_sem_valid, pol_sem_valid, sig_sem_valid}, e_opv[c]);
        check("op_semid",     op_semid,  e_sem[c]);
        check("op_tskid",     op_tskid,  e_tsk[c]);
        check("op_tskpri",    op_tskpri, e_pri[c]);
        check("rsp_valid",    rsp_valid, e_rspv[c]);
        check("rsp_ack",      rsp_ack,   e_rspack[c]);
        check("wakeup_valid", wakeup_valid, e_wkv[c]);
        check("wakeup_tskid", wakeup_tskid, e_wkt[c]);

        if (reset) begin
            reset_model();
        end else if (cke) begin
            if (op_now >= 0) sem_apply(0, op_now, int'(op_semid), int'(op_tskid), 1'b1, a, v, t);
            if (g >= 0) begin
                gop = int'(req_op[g*2 +: 2]);
                gs  = int'(req_semid[g*SW +: SW]);
                gt  = int'(req_tskid[g*TW +: TW]);
                gp  = int'(req_tskpri[g*PW +: PW]);
                sem_apply(1, gop, gs, gt, 1'b1, a, v, t);
                e_opv[c+1]    = 4'(1 << gop);
                l_sem = gs; l_tsk = gt; l_pri = gp;
                e_rspv[c+2]   = N'(1 << g);
                e_rspack[c+2] = a;
                e_wkv[c+2]    = v;
                e_wkt[c+2]    = t;
                ptr_m = (g + 1) % N;
                last_g[g] = c;
                $display("t=%0t grant req %0d op %0d sem %0d tsk %0d -> ack %0d wakeup %0d/%0d",
                         $time, g, gop, gs, gt, a, v, t);
            end
            e_sem[c+1] = l_sem; e_tsk[c+1] = l_tsk; e_pri[c+1] = l_pri;
            c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1;
        req_valid = '0; req_op = '0; req_semid = '0; req_tskid = '0; req_tskpri = '0;
        pol_sem_ack = 1'b0; sem_wakeup_valid = 1'b0; sem_wakeup_tskid = '0;
        for (int s = 0; s < NSEM; s++) set_sem(s, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        reset_model();

        // Poll with one count, then poll again on the now-empty semaphore
        set_sem(0, 1);
        set_req(0, 1'b1, 1, 0, 1, 0);
        run(4);
        idle_reqs();
        run(3);

        // All requesters signalling continuously: rotation 0,1,2,3,0...
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 0, 0, i, 0);
        run(12);
        idle_reqs();
        run(3);

        // Blocked wait, then a signal from another requester wakes it
        set_sem(0, 0);
        set_req(1, 1'b1, 2, 0, 5, 7);
        run(1);
        idle_reqs();
        run(2);
        set_req(2, 1'b1, 0, 0, 9, 0);
        run(1);
        idle_reqs();
        run(3);

        // Wait with counts available acquires immediately
        set_sem(0, 2);
        set_req(0, 1'b1, 2, 0, 3, 2);
        run(1);
        idle_reqs();
        run(3);
        check("semcnt_after_wai", sc[0][0], 1);

        // Clock-enable stall while the op bus is valid
        set_sem(1, 3);
        set_req(3, 1'b1, 1, 1, 6, 0);
        run(1);
        idle_reqs();
        cke = 1'b0;
        run(3);
        cke = 1'b1;
        run(4);
        check("semcnt_after_stall", sc[0][1], 2);

        // Reset while a poll is on the op bus: the response must never appear
        set_req(0, 1'b1, 1, 1, 2, 0);
        run(1);
        idle_reqs();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(3);
        for (int s = 0; s < NSEM; s++) set_sem(s, 1);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 0, 2, i, 0);
        run(2);
        idle_reqs();
        run(3);

        // Randomised traffic, including absent semaphore IDs and stalls
        for (int s = 0; s < NSEM; s++) set_sem(s, int'($urandom_range(0, 2)));
        for (int n = 0; n < 400; n++) begin
            cke = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)));
            end
            cycle();
        end
        cke = 1'b1;
        idle_reqs();
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
